refill_ctrl: RTL and testbench

- Cache-line refill controller between the instruction cache and data cache miss paths and one shared memory read port.
- Arbitrates between the two miss requests and issues a single line-aligned burst read.
- Collects LINE_WORDS beats into a line register, then writes the completed line into the shared return buffer with a one-cycle write-enable.
- Hands the requested (critical) word and a done pulse back to the winning cache.

---
 rtl/refill_ctrl_if.sv | 37 +++
 rtl/refill_ctrl.sv | 134 +++++++++++++
 tb/tb_refill_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/refill_ctrl_if.sv
// Bundle of the cache miss, memory read and line return signals around refill_ctrl.
// master is the controller's view; slave is the caches/memory side.
interface refill_ctrl_if #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
);
  logic                       i_req;
  logic [ADDR_W-1:0]          i_addr;
  logic                       i_done;
  logic                       d_req;
  logic [ADDR_W-1:0]          d_addr;
  logic                       d_done;
  logic                       rd_valid;
  logic [ADDR_W-1:0]          rd_addr;
  logic [7:0]                 rd_len;
  logic                       rd_ready;
  logic                       ret_valid;
  logic [WORD-1:0]            ret_data;
  logic                       ret_ready;
  logic                       line_we;
  logic [LINE_WORDS*WORD-1:0] line_out;
  logic [WORD-1:0]            crit_word;
  logic                       owner;

  modport master (
    input  i_req, i_addr, d_req, d_addr, rd_ready, ret_valid, ret_data,
    output i_done, d_done, rd_valid, rd_addr, rd_len, ret_ready,
           line_we, line_out, crit_word, owner
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, rd_ready, ret_valid, ret_data,
    input  i_done, d_done, rd_valid, rd_addr, rd_len, ret_ready,
           line_we, line_out, crit_word, owner
  );
endinterface

// File: rtl/refill_ctrl.sv
// Shared cache-line refill controller: round-robin I/D miss arbitration, one burst
// read per miss, line assembly, and a one-cycle line write / done pulse to the winner.
module refill_ctrl #(
  parameter int WORD       = 32,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int OFF_W      = 4
) (
  input logic          clk,
  input logic          rst,
  refill_ctrl_if.master bus
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [ADDR_W-1:0]      addr_reg;
  logic                   owner_reg;
  logic                   last_reg;
  logic [IDX_W-1:0]       cnt_reg;
  logic [IDX_W-1:0]       crit_idx_reg;
  logic [WORD-1:0]        line_reg [LINE_WORDS];
  logic [LINE_WORDS-1:0]  word_we;
  logic [LINE_WORDS*WORD-1:0] line_flat;

  logic grant_any, grant_d, beat_fire, last_beat;
  logic rd_valid, ret_ready, line_we, i_done, d_done;

  // A tie goes to whichever cache was not served last.
  assign grant_any = bus.i_req | bus.d_req;
  assign grant_d   = bus.d_req & (~bus.i_req | ~last_reg);
  assign beat_fire = (state_reg == DATA) & bus.ret_valid;
  assign last_beat = (cnt_reg == IDX_W'(LINE_WORDS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_any) state_next = ADDR;
      ADDR:    if (bus.rd_ready) state_next = DATA;
      DATA:    if (bus.ret_valid && last_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic, decoded from the registered state only
  always_comb begin
    rd_valid  = 1'b0;
    ret_ready = 1'b0;
    line_we   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state_reg)
      ADDR: rd_valid  = 1'b1;
      DATA: ret_ready = 1'b1;
      DONE: begin
        line_we = 1'b1;
        i_done  = ~owner_reg;
        d_done  = owner_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg  <= '0;
      owner_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (state_reg == IDLE && grant_any) begin
      addr_reg  <= grant_d ? bus.d_addr : bus.i_addr;
      owner_reg <= grant_d;
      last_reg  <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (state_reg == ADDR && bus.rd_ready) begin
      cnt_reg <= '0;
    end else if (beat_fire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The critical-word index follows the new grant only once its first beat lands,
  // so crit_word keeps showing the previous line until then.
  always_ff @(posedge clk) begin
    if (rst) begin
      crit_idx_reg <= '0;
    end else if (beat_fire && cnt_reg == '0) begin
      crit_idx_reg <= addr_reg[OFF_W-1 -: IDX_W];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      assign word_we[gi] = beat_fire && (cnt_reg == IDX_W'(gi));
      assign line_flat[gi*WORD +: WORD] = line_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (rst)             line_reg[k] <= '0;
      else if (word_we[k]) line_reg[k] <= bus.ret_data;
    end
  end

  // Byte-within-word address bits never matter to a word-granular refill.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_reg[OFF_W-IDX_W-1:0];

  assign bus.rd_valid  = rd_valid;
  assign bus.rd_addr   = {addr_reg[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign bus.rd_len    = 8'(LINE_WORDS - 1);
  assign bus.ret_ready = ret_ready;
  assign bus.line_we   = line_we;
  assign bus.line_out  = line_flat;
  assign bus.crit_word = line_reg[crit_idx_reg];
  assign bus.i_done    = i_done;
  assign bus.d_done    = d_done;
  assign bus.owner     = owner_reg;
endmodule

// File: tb/tb_refill_ctrl.sv
// Directed bench for refill_ctrl: hand-computed expectations checked with immediate assertions.
module tb_refill_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  refill_ctrl_if #(.WORD(32), .LINE_WORDS(4), .ADDR_W(32)) bus ();

  refill_ctrl #(.WORD(32), .LINE_WORDS(4), .ADDR_W(32), .OFF_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mkline(input logic [31:0] base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  // Four beats from base..base+3; optional idle cycle before each beat.
  task automatic beats(input logic [31:0] base, input bit bubble);
    for (int k = 0; k < 4; k++) begin
      if (bubble) begin
        bus.ret_valid = 1'b0;
        bus.ret_data  = 32'hDEAD_BEEF;
        tick();
        chk("bubble_ready", bus.ret_ready, 1);
      end
      bus.ret_valid = 1'b1;
      bus.ret_data  = base + 32'(k);
      tick();
      if (k < 3) chk("no_early_we", bus.line_we, 0);
    end
    bus.ret_valid = 1'b0;
  endtask

  initial begin
    bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_addr = '0;
    bus.rd_ready = 0; bus.ret_valid = 0; bus.ret_data = '0;
    tick(); tick();
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_ret_ready", bus.ret_ready, 0);
    chk("rst_line_we", bus.line_we, 0);
    chk("rst_dones", {bus.i_done, bus.d_done}, 0);
    chk("rst_line_out", bus.line_out, 0);
    chk("rst_owner", bus.owner, 0);
    rst = 1'b0;

    // Single ICache miss, back-to-back beats
    bus.i_req = 1; bus.i_addr = 32'h0000_1238; bus.rd_ready = 1;
    tick();
    chk("t1_rd_valid", bus.rd_valid, 1);
    chk("t1_rd_addr", bus.rd_addr, 32'h0000_1230);
    chk("t1_rd_len", bus.rd_len, 3);
    chk("t1_owner", bus.owner, 0);
    chk("t1_addr_no_ready", bus.ret_ready, 0);
    tick();
    chk("t1_ret_ready", bus.ret_ready, 1);
    beats(32'hA0, 0);
    chk("t1_line_we", bus.line_we, 1);
    chk("t1_i_done", bus.i_done, 1);
    chk("t1_d_done", bus.d_done, 0);
    chk("t1_line_out", bus.line_out, mkline(32'hA0));
    chk("t1_crit", bus.crit_word, 32'hA2);
    bus.i_req = 0;
    tick();
    chk("t1_idle_we", bus.line_we, 0);
    chk("t1_idle_done", bus.i_done, 0);
    chk("t1_hold_line", bus.line_out, mkline(32'hA0));

    // Tie after reset state: DCache first
    bus.i_req = 1; bus.i_addr = 32'h0000_2004;
    bus.d_req = 1; bus.d_addr = 32'h0000_3008;
    tick();
    chk("t2_owner_d", bus.owner, 1);
    chk("t2_rd_addr_d", bus.rd_addr, 32'h0000_3000);
    chk("t2_hold_line_addr", bus.line_out, mkline(32'hA0));
    chk("t2_hold_crit_addr", bus.crit_word, 32'hA2);
    tick();
    beats(32'hB0, 0);
    chk("t2_d_done", bus.d_done, 1);
    chk("t2_i_done_low", bus.i_done, 0);
    chk("t2_crit_d", bus.crit_word, 32'hB2);
    bus.d_req = 0;
    tick();
    tick();
    chk("t2_owner_i", bus.owner, 0);
    chk("t2_rd_addr_i", bus.rd_addr, 32'h0000_2000);
    tick();
    beats(32'hC0, 0);
    chk("t2_i_done", bus.i_done, 1);
    chk("t2_crit_i", bus.crit_word, 32'hC1);
    bus.i_req = 0;
    tick();
    // Last grant was ICache, so this tie goes to DCache, then the next to ICache
    bus.i_req = 1; bus.d_req = 1;
    tick();
    chk("t2_tie2_owner", bus.owner, 1);
    tick();
    beats(32'hD0, 0);
    chk("t2_tie2_d_done", bus.d_done, 1);
    bus.d_req = 0; bus.i_req = 0;
    tick();
    bus.i_req = 1; bus.d_req = 1;
    tick();
    chk("t2_tie3_owner", bus.owner, 0);
    tick();
    beats(32'hD8, 0);
    chk("t2_tie3_i_done", bus.i_done, 1);
    bus.d_req = 0; bus.i_req = 0;
    tick();

    // Address stall, stray beats during ADDR, bubbled data
    bus.i_req = 1; bus.i_addr = 32'h0000_040C; bus.rd_ready = 0;
    tick();
    bus.ret_valid = 1; bus.ret_data = 32'h5555_5555;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stall_valid", bus.rd_valid, 1);
      chk("t3_stall_addr", bus.rd_addr, 32'h0000_0400);
      chk("t3_stall_ready", bus.ret_ready, 0);
    end
    bus.ret_valid = 0; bus.rd_ready = 1;
    tick();
    chk("t3_data_ready", bus.ret_ready, 1);
    beats(32'hF0, 1);
    chk("t3_i_done", bus.i_done, 1);
    chk("t3_line_out", bus.line_out, mkline(32'hF0));
    chk("t3_crit", bus.crit_word, 32'hF3);
    bus.i_req = 0;
    tick();

    // Reset after the second beat
    bus.d_req = 1; bus.d_addr = 32'h0000_5008;
    tick(); tick();
    bus.ret_valid = 1; bus.ret_data = 32'h11; tick();
    bus.ret_data = 32'h12; tick();
    rst = 1; bus.ret_data = 32'h13;
    tick();
    chk("t5_rst_ready", bus.ret_ready, 0);
    chk("t5_rst_we", bus.line_we, 0);
    chk("t5_rst_done", bus.d_done, 0);
    chk("t5_rst_line", bus.line_out, 0);
    chk("t5_rst_owner", bus.owner, 0);
    rst = 0; bus.ret_valid = 0;
    tick();
    chk("t5_regrant_owner", bus.owner, 1);
    chk("t5_regrant_addr", bus.rd_addr, 32'h0000_5000);
    tick();
    bus.d_addr = 32'h0000_500C;
    beats(32'hE0, 0);
    chk("t5_d_done", bus.d_done, 1);
    chk("t5_line_out", bus.line_out, mkline(32'hE0));
    chk("t6_crit_latched", bus.crit_word, 32'hE2);
    bus.d_req = 0;
    tick();
    chk("t5_final_idle", bus.d_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
